uart_rx: RTL and testbench
==========================

# uart_rx

Memory-mapped UART receiver, the receive-side companion to the existing transmitter. It samples the serial `rx` pin at the 12 MHz system clock and assembles 8N1 frames. Received bytes are buffered in a small FIFO. The CPU reads data and status through the same one-cycle request / `ready` handshake used by the other I/O devices in the SoC address decoder.

## Interface
- `CLKS_PER_BIT`, default 1250: clk cycles per bit (12 MHz / 9600 baud); must be ≥ 4.
- `FIFO_DEPTH`, default 8: receive FIFO entries; power of two, 2..16.
- `clk`  in  1  system clock; all logic on posedge.
- `resetn`  in  1  reset, synchronous, active-low.
- `rx`  in  1  asynchronous serial input; idle high.
- `bus_read`  in  1  single-cycle read request.
- `bus_addr`  in  1  0 = DATA register, 1 = STATUS register; sampled with `bus_read`.
- `bus_rdata`  out  32  read data; valid while `bus_ready` = 1, then held.
- `bus_ready`  out  1  single-cycle acknowledge.
- `irq`  out  1  level; high while FIFO not empty.

## Operation
- Reset values: `bus_rdata` = 0, `bus_ready` = 0, `irq` = 0. FIFO is empty, sticky flags are cleared, FSM is in IDLE, and synchronizer flops are set to 1.
- `rx` passes through a 2-flop synchronizer (`rx_s`). Edge detection uses `rx_s` and its previous value.
- The FSM uses a bit counter (log2(CLKS_PER_BIT) bits) and a 3-bit bit index.
  - IDLE: on a falling edge of `rx_s`, load the counter with CLKS_PER_BIT/2 and go to START.
  - START: at counter expiry, sample `rx_s`. If 0, reload CLKS_PER_BIT and go to DATA with index 0. If 1, treat as a glitch and return to IDLE; nothing is pushed and no flag is set.
  - DATA: at each expiry, shift `rx_s` into the MSB of the shift register (LSB-first line order) and reload. After index 7 goes to STOP.
  - STOP: at expiry, sample `rx_s`.
    - 1: push the byte. If the FIFO is full with no pop in the same cycle, drop the byte and set OVERRUN.
    - 0: discard the byte and set FRAMING.
    - Either way, return to IDLE. The next frame needs `rx_s` to return high before a new falling edge is seen.
- DATA read (`bus_addr` = 0) returns {24'b0, head byte} and pops one entry. If the FIFO is empty it returns 0 and does not pop.
- STATUS read (`bus_addr` = 1) returns:
  - bit0 = not empty
  - bit1 = OVERRUN
  - bit2 = FRAMING
  - bit3 = full
  - bits[8:4] = occupancy count
  - all other bits 0
- A STATUS read clears OVERRUN and FRAMING in the same cycle it captures them. A flag set in that same cycle wins and stays 1.
- A reset in mid-frame abandons the frame. No partial byte is ever pushed.

## Timing
- Request to acknowledge: `bus_read` at cycle N gives `bus_ready` = 1 and `bus_rdata` valid at N+1. `bus_ready` is high for exactly one cycle.
- Back-to-back requests (every cycle) are legal; each gets its own acknowledge.
- The pop takes effect at N+1. A STATUS read at N+1 reflects the pop.
- The `rx` pin falling edge to START entry is 2–3 cycles (synchronizer latency).
- The stop-bit sample falls about 9.5 × CLKS_PER_BIT + 3 cycles after the `rx` falling edge. The FIFO push and `irq` rise are visible on the following cycle.
- Simultaneous push and pop:
  - When full, the pop frees the slot and the push succeeds; no OVERRUN, count stays FIFO_DEPTH.
  - When empty, the read returns 0 (the pushed byte is not bypassed) and count becomes 1.
- Pointers wrap modulo FIFO_DEPTH. The count has one extra bit so full and empty can be distinguished.

## Structure
- Package `uart_pkg` holds:
  - the FSM state encoding (IDLE, START, DATA, STOP);
  - the STATUS bit-position constants;
  - the register-select constants (DATA = 0, STATUS = 1);
  - the default CLKS_PER_BIT for 9600 baud at 12 MHz.
- Sub-module `uart_rx_fifo` is a synchronous FIFO parameterized by depth and width. It has `push`/`pop`/`din`/`dout`/`count`/`full`/`empty` and uses show-ahead (`dout` is the head). It is reusable for a future TX FIFO.
- The top level contains the synchronizer, FSM, flags and bus responder.

## Test plan
- Reset, then STATUS read → `bus_rdata` = 0x0 at N+1, `bus_ready` one cycle, `irq` = 0.
- Send frame 0xA5 at CLKS_PER_BIT = 16:
  - STATUS read → 0x11;
  - DATA read → 0xA5;
  - STATUS read → 0x0, `irq` = 0.
- 1-cycle low pulse on idle `rx` → stays in IDLE, STATUS = 0x0. Frame 0x3C with stop bit 0 → STATUS = 0x4; a second STATUS read → 0x0.
- Send 9 bytes 0x00..0x08 with no reads (depth 8):
  - STATUS → 0x8B (count 8, full, OVERRUN, not-empty);
  - eight DATA reads → 0x00..0x07;
  - ninth DATA read → 0x0.
- Fill the FIFO. Issue a DATA read in the same cycle as the 9th stop-bit sample → no OVERRUN, count stays 8, the read returns the first byte.
- Assert reset mid-DATA of frame 0x55, release it, then send 0x81 → FIFO holds only 0x81.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_e;

    localparam int STAT_NE      = 0;
    localparam int STAT_OVR     = 1;
    localparam int STAT_FRM     = 2;
    localparam int STAT_FULL    = 3;
    localparam int STAT_CNT_LSB = 4;
    localparam int STAT_CNT_W   = 5;

    localparam logic REG_DATA   = 1'b0;
    localparam logic REG_STATUS = 1'b1;

    localparam int SYS_CLK_HZ           = 12_000_000;
    localparam int BAUD                 = 9600;
    localparam int DEFAULT_CLKS_PER_BIT = SYS_CLK_HZ / BAUD;

    function automatic logic [31:0] status_word(
        input logic                  ne,
        input logic                  ovr,
        input logic                  frm,
        input logic                  full,
        input logic [STAT_CNT_W-1:0] cnt
    );
        logic [31:0] w;
        w                              = '0;
        w[STAT_NE]                     = ne;
        w[STAT_OVR]                    = ovr;
        w[STAT_FRM]                    = frm;
        w[STAT_FULL]                   = full;
        w[STAT_CNT_LSB +: STAT_CNT_W]  = cnt;
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO lands only
// when a pop frees a slot in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign count   = cnt_q;
    assign dout    = mem_q[rd_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + AW'(1);
        if (do_pop)  rd_d = rd_q + AW'(1);
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with receive FIFO and a one-cycle request/ready
// register port (DATA pops the head, STATUS clears the sticky flags).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rx,
    input  logic        bus_read,
    input  logic        bus_addr,
    output logic [31:0] bus_rdata,
    output logic        bus_ready,
    output logic        irq
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LOAD_FULL = CW'(CLKS_PER_BIT);
    localparam logic [CW-1:0] LOAD_HALF = CW'(CLKS_PER_BIT / 2);

    logic            sync1_q, rx_s_q, rx_prev_q;
    rx_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            ovr_q, ovr_d;
    logic            frm_q, frm_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            ready_q, ready_d;

    logic            fall, expire;
    logic            byte_done, frm_set, ovr_set;
    logic            stat_rd, fifo_pop;
    logic [7:0]      fifo_dout;
    logic [FW:0]     fifo_cnt;
    logic            fifo_full, fifo_empty;

    assign fall   = rx_prev_q && !rx_s_q;
    assign expire = (cnt_q == CW'(1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        frm_set   = 1'b0;
        if (state_q != ST_IDLE && !expire) cnt_d = cnt_q - CW'(1);
        unique case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d = ST_START;
                    cnt_d   = LOAD_HALF;
                end
            end
            ST_START: begin
                if (expire) begin
                    if (!rx_s_q) begin
                        state_d = ST_DATA;
                        cnt_d   = LOAD_FULL;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (expire) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    cnt_d   = LOAD_FULL;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (expire) begin
                    state_d   = ST_IDLE;
                    byte_done = rx_s_q;
                    frm_set   = !rx_s_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign stat_rd  = bus_read && (bus_addr == REG_STATUS);
    assign fifo_pop = bus_read && (bus_addr == REG_DATA) && !fifo_empty;
    // A full FIFO still accepts the byte when a pop lands in the same cycle.
    assign ovr_set  = byte_done && fifo_full && !fifo_pop;

    always_comb begin
        ovr_d   = ovr_set || (ovr_q && !stat_rd);
        frm_d   = frm_set || (frm_q && !stat_rd);
        ready_d = bus_read;
        rdata_d = rdata_q;
        if (bus_read) begin
            if (bus_addr == REG_STATUS) begin
                rdata_d = status_word(!fifo_empty, ovr_q, frm_q, fifo_full,
                                      STAT_CNT_W'(fifo_cnt));
            end else begin
                rdata_d = {24'b0, fifo_empty ? 8'h00 : fifo_dout};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            ovr_q     <= 1'b0;
            frm_q     <= 1'b0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
        end else begin
            sync1_q   <= rx;
            rx_s_q    <= sync1_q;
            rx_prev_q <= rx_s_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            ovr_q     <= ovr_d;
            frm_q     <= frm_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (byte_done),
        .pop    (fifo_pop),
        .din    (shift_q),
        .dout   (fifo_dout),
        .count  (fifo_cnt),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign bus_rdata = rdata_q;
    assign bus_ready = ready_q;
    assign irq       = !fifo_empty;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level reference model (byte queue + flags)
// compared every cycle, plus directed literal checks.
module tb_uart_rx;
    localparam int CPB      = 16;
    localparam int DEPTH    = 8;
    localparam int PUSH_LAT = 3 + CPB / 2 + 9 * CPB;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        rx = 1'b1;
    logic        bus_read = 1'b0;
    logic        bus_addr = 1'b0;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        irq;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rx        (rx),
        .bus_read  (bus_read),
        .bus_addr  (bus_addr),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit check_en = 1'b0;

    typedef struct {
        int         at;
        logic [7:0] data;
        bit         ok;
    } ev_t;

    logic [7:0]  mq[$];
    ev_t         evq[$];
    bit          m_ovr, m_frm;
    bit          exp_ready;
    logic [31:0] exp_rdata;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Reference model: one step per clock edge, frame completions are
    // scheduled events carrying the byte and whether the stop bit was good.
    always @(posedge clk) begin : model
        bit          pop;
        logic [31:0] st;
        cyc++;
        if (!resetn) begin
            mq.delete();
            evq.delete();
            m_ovr     = 1'b0;
            m_frm     = 1'b0;
            exp_ready = 1'b0;
            exp_rdata = '0;
        end else begin
            pop = 1'b0;
            st  = {23'b0, 5'(mq.size()), mq.size() == DEPTH,
                   m_frm, m_ovr, mq.size() != 0};
            exp_ready = bus_read;
            if (bus_read) begin
                if (bus_addr) begin
                    exp_rdata = st;
                    m_ovr = 1'b0;
                    m_frm = 1'b0;
                end else if (mq.size() != 0) begin
                    exp_rdata = {24'b0, mq[0]};
                    pop = 1'b1;
                end else begin
                    exp_rdata = '0;
                end
            end
            if (pop) void'(mq.pop_front());
            if (evq.size() != 0 && evq[0].at == cyc) begin
                if (!evq[0].ok) m_frm = 1'b1;
                else if (mq.size() == DEPTH) m_ovr = 1'b1;
                else mq.push_back(evq[0].data);
                void'(evq.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("ready", 32'(bus_ready), 32'(exp_ready));
            chk("irq", 32'(irq), 32'(mq.size() != 0));
            chk("rdata", bus_rdata, exp_rdata);
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input bit a, input logic [31:0] want, input string nm);
        bus_read = 1'b1;
        bus_addr = a;
        wait_cycles(1);
        bus_read = 1'b0;
        bus_addr = 1'b0;
        chk({nm, "_ready"}, 32'(bus_ready), 32'd1);
        chk(nm, bus_rdata, want);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop, input int gap);
        evq.push_back('{cyc + PUSH_LAT, d, stop});
        rx = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_cycles(CPB);
        end
        rx = stop;
        wait_cycles(CPB);
        rx = 1'b1;
        wait_cycles(gap);
    endtask

    bit rnd_done;

    initial begin
        @(posedge clk);
        #1;
        check_en = 1'b1;
        wait_cycles(3);
        resetn = 1'b1;
        wait_cycles(2);

        rd(1'b1, 32'h0, "reset_status");
        chk("reset_irq", 32'(irq), 32'd0);
        wait_cycles(1);
        chk("ready_one_cycle", 32'(bus_ready), 32'd0);

        send_frame(8'hA5, 1'b1, 4);
        rd(1'b1, 32'h11, "a5_status");
        rd(1'b0, 32'hA5, "a5_data");
        rd(1'b1, 32'h0, "a5_status_after");
        chk("a5_irq_low", 32'(irq), 32'd0);

        rx = 1'b0;
        wait_cycles(1);
        rx = 1'b1;
        wait_cycles(40);
        rd(1'b1, 32'h0, "glitch_status");
        send_frame(8'h3C, 1'b0, 4);
        rd(1'b1, 32'h4, "framing_status");
        rd(1'b1, 32'h0, "framing_cleared");

        for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1, 3);
        rd(1'b1, 32'h8B, "overrun_status");
        for (int i = 0; i < 8; i++) rd(1'b0, 32'(i), "drain_data");
        rd(1'b0, 32'h0, "empty_data");

        for (int i = 0; i < 8; i++) send_frame(8'(8'h10 + i), 1'b1, 3);
        fork
            send_frame(8'h18, 1'b1, 4);
            begin
                wait_cycles(PUSH_LAT - 1);
                rd(1'b0, 32'h10, "sim_pushpop_data");
            end
        join
        rd(1'b1, 32'h89, "sim_pushpop_status");
        for (int i = 1; i < 9; i++) rd(1'b0, 32'(8'h10 + i), "full_drain");

        rx = 1'b0;
        wait_cycles(CPB);
        rx = 1'b1;
        wait_cycles(CPB);
        rx = 1'b0;
        wait_cycles(CPB / 2);
        resetn = 1'b0;
        rx = 1'b1;
        wait_cycles(3);
        resetn = 1'b1;
        wait_cycles(4);
        send_frame(8'h81, 1'b1, 4);
        rd(1'b1, 32'h11, "post_reset_status");
        rd(1'b0, 32'h81, "post_reset_data");
        rd(1'b1, 32'h0, "post_reset_empty");

        rnd_done = 1'b0;
        fork
            begin
                for (int f = 0; f < 24; f++) begin
                    send_frame(8'($urandom), $urandom_range(7) != 0,
                               $urandom_range(20, 2));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    if ($urandom_range(11) == 0) begin
                        bus_read = 1'b1;
                        bus_addr = 1'($urandom_range(1));
                    end else begin
                        bus_read = 1'b0;
                    end
                    wait_cycles(1);
                end
                bus_read = 1'b0;
            end
        join
        wait_cycles(4);
        for (int i = 0; i < DEPTH + 1; i++) begin
            bus_read = 1'b1;
            bus_addr = 1'b0;
            wait_cycles(1);
        end
        bus_read = 1'b0;
        wait_cycles(2);
        chk("final_irq", 32'(irq), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
